// File: rtl/tdm_demux_1x4_pkg.sv
// tdm_demux_1x4_pkg: shared TDM framing constants and receiver state encoding
package tdm_demux_1x4_pkg;
    localparam int TDM_NUM_SLOTS = 4;
    localparam int TDM_SLOT_W    = 2;
    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;
endpackage

// File: rtl/tdm_demux_1x4_if.sv
// tdm_demux_1x4_if: serial lane in (din/din_valid/frame_sync), committed channels and status out
interface tdm_demux_1x4_if #(parameter int WIDTH = 1);
    import tdm_demux_1x4_pkg::*;
    logic [WIDTH-1:0]      din;
    logic                  din_valid;
    logic                  frame_sync;
    logic [WIDTH-1:0]      dout0;
    logic [WIDTH-1:0]      dout1;
    logic [WIDTH-1:0]      dout2;
    logic [WIDTH-1:0]      dout3;
    logic                  frame_done;
    logic [TDM_SLOT_W-1:0] sel;
    logic                  locked;
    logic                  sync_err;
    modport master (
        output din, din_valid, frame_sync,
        input  dout0, dout1, dout2, dout3, frame_done, sel, locked, sync_err
    );
    modport slave (
        input  din, din_valid, frame_sync,
        output dout0, dout1, dout2, dout3, frame_done, sel, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux_1x4_slot_reg.sv
// tdm_slot_reg: per-slot shadow + commit register; ports clk, rst, load, commit, d in, q out
module tdm_slot_reg #(
    parameter int WIDTH  = 1,
    parameter bit BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             commit,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] shadow;
    // the last slot commits straight from the lane on the same beat it arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            q      <= '0;
        end else begin
            if (load) shadow <= d;
            if (commit) q <= BYPASS ? d : shadow;
        end
    end
endmodule

// File: rtl/tdm_demux_1x4.sv
// tdm_demux_1x4: 4-slot TDM receiver; clk, rst, bus (slave): lane in, framed channels and status out
module tdm_demux_1x4
    import tdm_demux_1x4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input logic            clk,
    input logic            rst,
    tdm_demux_1x4_if.slave bus
);
    state_t                   state, state_n;
    logic [TDM_SLOT_W-1:0]    sel, sel_n;
    logic [TDM_NUM_SLOTS-1:0] load;
    logic                     commit, err, frame_done, sync_err;
    logic [WIDTH-1:0]         dq [TDM_NUM_SLOTS];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_HUNT;
            sel        <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_n;
            sel        <= sel_n;
            frame_done <= commit;
            sync_err   <= err;
        end
    end
    // frame_sync always restarts a frame; it is an error only when it cuts a partial frame short
    always_comb begin
        state_n = state;
        sel_n   = sel;
        load    = '0;
        commit  = 1'b0;
        err     = 1'b0;
        if (bus.din_valid) begin
            if (bus.frame_sync) begin
                err     = state == ST_LOCKED && sel != '0;
                state_n = ST_LOCKED;
                sel_n   = TDM_SLOT_W'(1);
                load    = TDM_NUM_SLOTS'(1);
            end else if (state == ST_LOCKED) begin
                if (sel == '0) begin
                    err     = 1'b1;
                    state_n = ST_HUNT;
                end else begin
                    load   = TDM_NUM_SLOTS'(1) << sel;
                    sel_n  = sel + 1'b1;
                    commit = sel == TDM_SLOT_W'(TDM_NUM_SLOTS - 1);
                end
            end
        end
    end
    always_comb begin
        bus.locked     = state == ST_LOCKED;
        bus.sel        = sel;
        bus.frame_done = frame_done;
        bus.sync_err   = sync_err;
        bus.dout0      = dq[0];
        bus.dout1      = dq[1];
        bus.dout2      = dq[2];
        bus.dout3      = dq[3];
    end
    for (genvar k = 0; k < TDM_NUM_SLOTS; k++) begin : g_slot
        tdm_slot_reg #(
            .WIDTH  (WIDTH),
            .BYPASS (k == TDM_NUM_SLOTS - 1)
        ) u_slot (
            .clk    (clk),
            .rst    (rst),
            .load   (load[k]),
            .commit (commit),
            .d      (bus.din),
            .q      (dq[k])
        );
    end
endmodule
